// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam int unsigned RO_ADDR0_DEF = 24;  // USR status cell
  localparam int unsigned RO_ADDR1_DEF = 25;  // UDRR receive-data cell

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_CPU) ? OWN_DMA : OWN_CPU;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, DMA and memory-side signals around the arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              cpu_err;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic              dma_err;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_err, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_err, dma_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_err, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_err, dma_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_grant.sv
// Grant decision: a lone requester wins; on a tie the pointer side wins.
module dmem_arb_grant
  import dmem_arb_pkg::*;
(
  input  logic   i_cpu_req,
  input  logic   i_dma_req,
  input  owner_e i_pointer,
  output owner_e o_owner
);

  always_comb begin
    o_owner = OWN_CPU;
    if (i_cpu_req && i_dma_req) begin
      o_owner = i_pointer;
    end else if (i_dma_req) begin
      o_owner = OWN_DMA;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA data-memory arbiter: IDLE -> ACCESS -> RESP, one access per 3 cycles.
// Define DMEM_ARB_RR_EN for round-robin ties; default build is fixed CPU priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int unsigned RO_ADDR0 = RO_ADDR0_DEF,
  parameter int unsigned RO_ADDR1 = RO_ADDR1_DEF
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  owner_e            r_owner;
  owner_e            w_win;
  owner_e            w_ptr;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;
  logic              w_grant;
  logic              w_access;
  logic              w_resp;
  logic              w_ro;

`ifdef DMEM_ARB_RR_EN
  owner_e r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= OWN_CPU;
    end else if (w_grant) begin
      r_ptr <= other_owner(w_win);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = OWN_CPU;
`endif

  dmem_arb_grant u_grant (
    .i_cpu_req (bus.cpu_req),
    .i_dma_req (bus.dma_req),
    .i_pointer (w_ptr),
    .o_owner   (w_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_access    = 1'b0;
    w_resp      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_access    = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_resp      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_ro = (r_addr == ADDR_W'(RO_ADDR0)) || (r_addr == ADDR_W'(RO_ADDR1));

  // Requests are latched only at grant, so requesters may drop req early.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OWN_CPU;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_win;
        r_err   <= 1'b0;
        if (w_win == OWN_CPU) begin
          r_we    <= bus.cpu_we;
          r_addr  <= bus.cpu_addr;
          r_wdata <= bus.cpu_wdata;
        end else begin
          r_we    <= bus.dma_we;
          r_addr  <= bus.dma_addr;
          r_wdata <= bus.dma_wdata;
        end
      end
      if (w_access) begin
        r_err <= r_we && w_ro;
        if (!r_we) begin
          if (r_owner == OWN_CPU) begin
            r_cpu_rdata <= bus.mem_rdata;
          end else begin
            r_dma_rdata <= bus.mem_rdata;
          end
        end
      end
    end
  end

  // rst gates the strobes directly so a reset in ACCESS commits no write
  // and a reset in RESP produces no ack.
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_we    = w_access && r_we && !w_ro && !rst;
  assign bus.mem_re    = w_access && !r_we && !rst;

  assign bus.cpu_ack   = w_resp && !rst && (r_owner == OWN_CPU);
  assign bus.dma_ack   = w_resp && !rst && (r_owner == OWN_DMA);
  assign bus.cpu_err   = bus.cpu_ack && r_err;
  assign bus.dma_err   = bus.dma_ack && r_err;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.dma_rdata = r_dma_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases then random CPU/DMA traffic.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 24) return 32'h0000_00C3;
    if (i == 25) return 32'h0000_005A;
    return 32'hA5A5_0000 | 32'(i * 3);
  endfunction

  // memory behind the arbiter
  logic [31:0] tb_mem [32];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32; i++) tb_mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (bus.mem_we) begin
      tb_mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = bus.mem_re ? tb_mem[bus.mem_addr[4:0]] : 32'h0;

  // reference model: side 0 = CPU, side 1 = DMA
  logic [31:0] model_mem [32];
  bit          rq_pend [2];
  bit          rq_we   [2];
  logic [31:0] rq_addr [2];
  logic [31:0] rq_data [2];
  logic [31:0] exp_rd  [2];
  int          m_ptr;
`ifdef DMEM_ARB_RR_EN
  int exp_order [4] = '{0, 1, 0, 1};
`else
  int exp_order [4] = '{0, 0, 0, 0};
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input int s);
    return (s == 0) ? bus.cpu_ack : bus.dma_ack;
  endfunction

  function automatic logic err_of(input int s);
    return (s == 0) ? bus.cpu_err : bus.dma_err;
  endfunction

  task automatic drive_bus();
    bus.cpu_req   = rq_pend[0];
    bus.cpu_we    = rq_we[0];
    bus.cpu_addr  = rq_addr[0];
    bus.cpu_wdata = rq_data[0];
    bus.dma_req   = rq_pend[1];
    bus.dma_we    = rq_we[1];
    bus.dma_addr  = rq_addr[1];
    bus.dma_wdata = rq_data[1];
  endtask

  task automatic set_req(input int s, input bit we, input logic [31:0] addr, input logic [31:0] data);
    rq_pend[s] = 1'b1;
    rq_we[s]   = we;
    rq_addr[s] = addr;
    rq_data[s] = data;
  endtask

  task automatic model_reset();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    m_ptr     = 0;
  endtask

  task automatic apply_reset();
    rq_pend[0] = 1'b0;
    rq_pend[1] = 1'b0;
    drive_bus();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Called at a negedge with the arbiter idle; runs one full grant and
  // returns the side whose ack the DUT actually raised (-1 if none).
  task automatic do_grant(input bit drop_early, output int obs);
    int          w;
    bit          ro;
    bit          werr;
    logic [31:0] a;
    if (rq_pend[0] && rq_pend[1]) w = m_ptr;
    else if (rq_pend[1])          w = 1;
    else                          w = 0;
`ifdef DMEM_ARB_RR_EN
    m_ptr = 1 - w;
`endif
    a    = rq_addr[w];
    ro   = (a == 32'd24) || (a == 32'd25);
    werr = rq_we[w] && ro;
    drive_bus();

    @(negedge clk);
    check_val("acc_mem_we",   bus.mem_we, rq_we[w] && !ro);
    check_val("acc_mem_re",   bus.mem_re, !rq_we[w]);
    check_val("acc_mem_addr", bus.mem_addr, a);
    if (rq_we[w]) check_val("acc_mem_wdata", bus.mem_wdata, rq_data[w]);
    check_val("acc_no_ack", {bus.cpu_ack, bus.dma_ack}, 2'b00);
    if (!rq_we[w])  exp_rd[w] = model_mem[a[4:0]];
    else if (!ro)   model_mem[a[4:0]] = rq_data[w];
    if (drop_early) begin
      rq_pend[w] = 1'b0;
      drive_bus();
    end

    @(negedge clk);
    obs = bus.dma_ack ? 1 : (bus.cpu_ack ? 0 : -1);
    check_val("resp_ack",       ack_of(w), 1'b1);
    check_val("resp_err",       err_of(w), werr);
    check_val("resp_other_ack", ack_of(1 - w), 1'b0);
    check_val("resp_other_err", err_of(1 - w), 1'b0);
    check_val("resp_cpu_rdata", bus.cpu_rdata, exp_rd[0]);
    check_val("resp_dma_rdata", bus.dma_rdata, exp_rd[1]);
    check_val("resp_mem_idle",  {bus.mem_we, bus.mem_re}, 2'b00);
    rq_pend[w] = 1'b0;
    drive_bus();

    @(negedge clk);
    check_val("idle_ack", {bus.cpu_ack, bus.dma_ack}, 2'b00);
    check_val("idle_mem", {bus.mem_we, bus.mem_re}, 2'b00);
  endtask

  initial begin
    int obs;
    for (int i = 0; i < 32; i++) model_mem[i] = init_word(i);
    for (int s = 0; s < 2; s++) begin
      rq_pend[s] = 1'b0;
      rq_we[s]   = 1'b0;
      rq_addr[s] = '0;
      rq_data[s] = '0;
    end
    model_reset();
    drive_bus();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_acks",   {bus.cpu_ack, bus.dma_ack}, 2'b00);
    check_val("rst_errs",   {bus.cpu_err, bus.dma_err}, 2'b00);
    check_val("rst_cpu_rd", bus.cpu_rdata, 32'h0);
    check_val("rst_dma_rd", bus.dma_rdata, 32'h0);
    check_val("rst_mem",    {bus.mem_we, bus.mem_re}, 2'b00);
    rst = 1'b0;

    set_req(0, 1'b1, 32'd5, 32'hDEADBEEF);
    do_grant(1'b0, obs);
    check_val("cpu_wr_owner", obs, 0);

    set_req(1, 1'b0, 32'd5, 32'h0);
    do_grant(1'b0, obs);
    check_val("dma_rd_owner", obs, 1);
    check_val("dma_rd_data",  bus.dma_rdata, 32'hDEADBEEF);

    set_req(0, 1'b1, 32'd24, 32'h1234_5678);
    do_grant(1'b0, obs);
    set_req(0, 1'b0, 32'd24, 32'h0);
    do_grant(1'b0, obs);
    check_val("ro_usr_read", bus.cpu_rdata, 32'h0000_00C3);

    apply_reset();
    for (int k = 0; k < 4; k++) begin
      if (!rq_pend[0]) set_req(0, 1'b0, 32'(k), 32'h0);
      if (!rq_pend[1]) set_req(1, 1'b0, 32'(k + 8), 32'h0);
      do_grant(1'b0, obs);
      check_val("tie_order", obs, exp_order[k]);
    end
    while (rq_pend[0] || rq_pend[1]) do_grant(1'b0, obs);

    // reset during RESP of a DMA read
    set_req(1, 1'b0, 32'd5, 32'h0);
    drive_bus();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rq_pend[1] = 1'b0;
    drive_bus();
    #1;
    check_val("rstresp_dma_ack", bus.dma_ack, 1'b0);
    check_val("rstresp_cpu_ack", bus.cpu_ack, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_val("rstresp_dma_rd", bus.dma_rdata, 32'h0);
    check_val("rstresp_mem",    {bus.mem_we, bus.mem_re, bus.dma_ack}, 3'b000);

    // CPU drops req right after being granted
    set_req(0, 1'b0, 32'd5, 32'h0);
    do_grant(1'b1, obs);
    check_val("drop_owner", obs, 0);
    repeat (2) begin
      @(negedge clk);
      check_val("drop_no_regrant", {bus.mem_we, bus.mem_re, bus.cpu_ack}, 3'b000);
    end

    for (int n = 0; n < 200; n++) begin
      for (int s = 0; s < 2; s++) begin
        if (!rq_pend[s] && $urandom_range(0, 2) != 0) begin
          set_req(s, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 32'(24 + $urandom_range(0, 1))
                                              : 32'($urandom_range(0, 31)),
                  $urandom);
        end
      end
      if (!rq_pend[0] && !rq_pend[1]) begin
        set_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 31)), $urandom);
      end
      do_grant(1'($urandom_range(0, 9) == 0), obs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning width of every address port.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning width of every data port.
REQ-003 The block SHALL have parameter RO_ADDR0, default 24, meaning read-only status cell address (USR).
REQ-004 The block SHALL have parameter RO_ADDR1, default 25, meaning read-only receive-data cell address (UDRR).
REQ-005 The block SHALL have port clk, input, 1, the system clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have ports cpu_req, cpu_we (input, 1), cpu_addr (input, ADDR_W) and cpu_wdata (input, DATA_W), the CPU load/store request.
REQ-008 The block SHALL have ports cpu_ack, cpu_err (output, 1) and cpu_rdata (output, DATA_W), the CPU response.
REQ-009 The block SHALL have ports dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_err and dma_rdata, identical in width and meaning to the cpu_* ports, for the DMA requester.
REQ-010 The block SHALL have memory-side outputs mem_addr (ADDR_W), mem_wdata (DATA_W), mem_we (1) and mem_re (1), and input mem_rdata (DATA_W), which is combinational and valid while mem_re=1 and mem_we=0.

Function
REQ-011 The FSM SHALL have states IDLE, ACCESS and RESP; the encoding is implementation choice.
REQ-012 In IDLE with at least one req high, the block SHALL register the winner's we/addr/wdata plus an owner bit and enter ACCESS on the next edge.
REQ-013 In ACCESS, the block SHALL drive mem_addr/mem_wdata from the registers, with mem_re=!we and mem_we=we.
REQ-014 In ACCESS, the block SHALL force mem_we=0 when the address equals RO_ADDR0 or RO_ADDR1, and SHALL set the registered err bit in that case.
REQ-015 At the end of ACCESS, the block SHALL capture mem_rdata into the owner's rdata register on a read and enter RESP.
REQ-016 In RESP, the block SHALL pulse the owner's ack for exactly one cycle, drive the owner's err from the err bit, and return to IDLE.
REQ-017 Latency from a req sampled in IDLE to ack SHALL be 2 cycles; there SHALL be one idle cycle between back-to-back grants, i.e. at most one access per 3 cycles.
REQ-018 Outside ACCESS, mem_we and mem_re SHALL both be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-019 A requester SHALL hold req, we, addr and wdata stable until its ack; the arbiter SHALL NOT re-sample them during ACCESS or RESP.
REQ-020 A requester that drops req before ack SHALL still receive the ack pulse, and the access SHALL complete.
REQ-021 rdata SHALL hold its value until that requester's next read completes; on writes, rdata SHALL be unchanged.
REQ-022 The non-owner's ack and err SHALL be 0.

Reset
REQ-023 When rst=1 at a rising edge, the block SHALL move to IDLE, clear both ack and err outputs, both rdata registers, mem_we and mem_re, and set the priority pointer to CPU.
REQ-024 When rst is asserted during ACCESS or RESP, the block SHALL abort the access, issue no ack, and leave the memory write uncommitted only if rst is asserted in the same cycle as ACCESS.

Configuration
REQ-025 With macro DMEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on a simultaneous request the pointer side wins, and the pointer toggles to the other side after each grant.
REQ-026 Without DMEM_ARB_RR_EN, CPU SHALL always win a simultaneous request (fixed priority), and no pointer register SHALL exist.

Structure
REQ-027 A shared package dmem_arb_pkg SHALL hold the state enumeration, the owner encoding (OWN_CPU=0, OWN_DMA=1) and the default RO address constants.
REQ-028 The grant decision SHALL be a sub-module dmem_arb_grant (inputs: cpu_req, dma_req, pointer; output: owner), which is combinational apart from the pointer under DMEM_ARB_RR_EN.

Verification
REQ-029 Reset, then a CPU write of addr 5 with data 0xDEADBEEF: mem_we=1 for exactly 1 cycle, cpu_ack 2 cycles after the req is sampled, cpu_err=0.
REQ-030 A DMA read of addr 5 after that write: dma_rdata=0xDEADBEEF with dma_ack, and cpu_ack=0 throughout.
REQ-031 A CPU write to addr 24: mem_we stays 0, and cpu_ack=1 with cpu_err=1; a subsequent read of addr 24 returns the USR value.
REQ-032 Simultaneous cpu_req and dma_req held for 4 grants: with DMEM_ARB_RR_EN the order is CPU, DMA, CPU, DMA; without it the order is CPU, CPU, CPU, CPU.
REQ-033 rst pulsed during RESP of a DMA read: no dma_ack, state IDLE, dma_rdata=0 on the next cycle.
REQ-034 cpu_req dropped one cycle after being sampled: cpu_ack still pulses once, and no second grant follows.
